// File: rtl/addsub_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_pkg : shared FSM encoding and nibble width for addsub_rr_seq |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package addsub_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   function automatic int nib_count(input int width);
      return width / NIB_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_nib.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_nib : combinational 4-bit a + (b ^ sub) + cin, exposing the |
// |              carry into the MSB for overflow detection            |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module addsub_nib
   import addsub_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic [NIB_W-1:0] sum,
   output logic             cout,
   output logic             msb_cin
);

   logic [NIB_W-1:0] bx;
   logic [NIB_W-1:0] lo;
   logic [1:0]       hi;

   // Low three bits first so the carry into bit 3 is visible on its own
   always_comb begin
      bx      = b ^ {NIB_W{sub}};
      lo      = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
      hi      = {1'b0, a[3]} + {1'b0, bx[3]} + {1'b0, lo[3]};
      sum     = {hi[0], lo[2:0]};
      cout    = hi[1];
      msb_cin = lo[3];
   end

endmodule
`default_nettype wire

// File: rtl/addsub_rr_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addsub_rr_seq : two-requester round-robin, nibble-serial add/sub   |
// |                 Optional macro ADDSUB_RR_SEQ_OVF_EN enables rsp_ovf |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module addsub_rr_seq
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_sub,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_sub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_cout,
   output logic             rsp_ovf,
   output logic             rsp_id
);

   localparam int N     = nib_count(WIDTH);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   state_t           state;
   state_t           state_nxt;
   logic             ptr;
   logic             id_r;
   logic             sub_r;
   logic             carry_r;
   logic             cout_r;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [CNT_W-1:0] cnt;

   logic             gnt0;
   logic             gnt1;
   logic             accept;
   logic             last_nib;
   logic [NIB_W-1:0] nib_sum;
   logic             nib_cout;
`ifdef ADDSUB_RR_SEQ_OVF_EN
   logic             nib_msb_cin;
   logic             ovf_r;
`else
   logic             unused_nib_msb_cin;
`endif

   // Favoured requester wins if valid; the other only when it is idle
   always_comb begin
      gnt0 = ptr ? (req0_valid & ~req1_valid) : req0_valid;
      gnt1 = ptr ? req1_valid : (req1_valid & ~req0_valid);
   end

   assign req0_ready = rst_n & (state == IDLE) & gnt0;
   assign req1_ready = rst_n & (state == IDLE) & gnt1;
   assign accept     = req0_ready | req1_ready;
   assign last_nib   = (state == EXEC) && (cnt == CNT_W'(N - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)                state_nxt = EXEC;
         EXEC:    if (last_nib)              state_nxt = RESP;
         RESP:    if (rsp_valid & rsp_ready) state_nxt = IDLE;
         default:                            state_nxt = IDLE;
      endcase
   end

   addsub_nib u_nib (
      .a       (a_sh[NIB_W-1:0]),
      .b       (b_sh[NIB_W-1:0]),
      .sub     (sub_r),
      .cin     (carry_r),
      .sum     (nib_sum),
      .cout    (nib_cout),
`ifdef ADDSUB_RR_SEQ_OVF_EN
      .msb_cin (nib_msb_cin)
`else
      .msb_cin (unused_nib_msb_cin)
`endif
   );

   // Result nibbles enter at the top while operand a drains from the bottom
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= 1'b0;
         id_r    <= 1'b0;
         sub_r   <= 1'b0;
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
         a_sh    <= '0;
         b_sh    <= '0;
         cnt     <= '0;
`ifdef ADDSUB_RR_SEQ_OVF_EN
         ovf_r   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_sh    <= req1_ready ? req1_a   : req0_a;
            b_sh    <= req1_ready ? req1_b   : req0_b;
            sub_r   <= req1_ready ? req1_sub : req0_sub;
            carry_r <= req1_ready ? req1_sub : req0_sub;
            id_r    <= req1_ready;
            ptr     <= ~req1_ready;
            cnt     <= '0;
         end else if (state == EXEC) begin
            a_sh    <= (a_sh >> NIB_W) | (WIDTH'(nib_sum) << (WIDTH - NIB_W));
            b_sh    <= b_sh >> NIB_W;
            carry_r <= nib_cout;
            cnt     <= cnt + CNT_W'(1);
            if (last_nib) begin
               cout_r <= nib_cout;
`ifdef ADDSUB_RR_SEQ_OVF_EN
               ovf_r  <= nib_msb_cin ^ nib_cout;
`endif
            end
         end
      end
   end

   assign rsp_valid = (state == RESP);
   assign rsp_data  = a_sh;
   assign rsp_cout  = cout_r;
   assign rsp_id    = id_r;
`ifdef ADDSUB_RR_SEQ_OVF_EN
   assign rsp_ovf   = ovf_r;
`else
   assign rsp_ovf   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_addsub_rr_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_addsub_rr_seq : directed vector table plus handshake/reset cases|
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_addsub_rr_seq;

   localparam int WIDTH = 16;
   localparam int N     = WIDTH / 4;
`ifdef ADDSUB_RR_SEQ_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             req0_valid, req0_ready, req0_sub;
   logic [WIDTH-1:0] req0_a, req0_b;
   logic             req1_valid, req1_ready, req1_sub;
   logic [WIDTH-1:0] req1_a, req1_b;
   logic             rsp_valid, rsp_ready, rsp_cout, rsp_ovf, rsp_id;
   logic [WIDTH-1:0] rsp_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          rq;
      logic [15:0] a;
      logic [15:0] b;
      bit          sub;
      logic [15:0] d;
      bit          cout;
      bit          ovf;
   } vec_t;

   vec_t vecs [7];

   addsub_rr_seq #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sub   (req1_sub),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_cout   (rsp_cout),
      .rsp_ovf    (rsp_ovf),
      .rsp_id     (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Count clocks from just after an acceptance edge until rsp_valid rises
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 12) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input vec_t v, input string tag);
      int waitc;
      int lat;
      @(negedge clk);
      if (v.rq) begin
         req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_sub = v.sub;
      end else begin
         req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_sub = v.sub;
      end
      #1;
      waitc = 0;
      while (!(v.rq ? req1_ready : req0_ready) && waitc < 10) begin
         @(negedge clk); #1;
         waitc++;
      end
      chk({tag, " ready"}, v.rq ? req1_ready : req0_ready, 1);
      chk({tag, " other_ready"}, v.rq ? req0_ready : req1_ready, 0);
      @(posedge clk); #1;
      // Scramble the request inputs to prove the operands were captured
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 16'hDEAD; req0_b = 16'hBEEF; req0_sub = ~v.sub;
      req1_a = 16'hDEAD; req1_b = 16'hBEEF; req1_sub = ~v.sub;
      wait_rsp(lat);
      chk({tag, " latency"}, lat, N);
      chk({tag, " data"}, rsp_data, v.d);
      chk({tag, " cout"}, rsp_cout, v.cout);
      chk({tag, " ovf"}, rsp_ovf, v.ovf & OVF_EN);
      chk({tag, " id"}, rsp_id, v.rq);
      @(posedge clk); #1;
      chk({tag, " done"}, rsp_valid, 0);
   endtask

   initial begin
      int order [4];
      int acc_cyc [4];
      int k;
      int rdy_cycles;
      int lat;
      logic [WIDTH-1:0] held;

      vecs[0] = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 16'h0005, 16'h000E, 1'b1, 16'hFFF7, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

      rst_n = 1'b0;
      req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; req0_sub = 1'b0;
      req1_valid = 1'b1; req1_a = 16'h0003; req1_b = 16'h0004; req1_sub = 1'b0;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst rsp_valid", rsp_valid, 0);
      chk("rst rsp_data", rsp_data, 0);
      chk("rst rsp_cout", rsp_cout, 0);
      chk("rst rsp_ovf", rsp_ovf, 0);
      chk("rst rsp_id", rsp_id, 0);
      chk("rst req0_ready", req0_ready, 0);
      chk("rst req1_ready", req1_ready, 0);

      // Both requesters valid from reset release: strict alternation
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      rdy_cycles = 0;
      for (int c = 0; c < 60 && k < 4; c++) begin
         #1;
         if (req0_ready && req1_ready) chk("rr both_ready", 1, 0);
         if (req0_ready || req1_ready) begin
            rdy_cycles++;
            order[k]   = req1_ready ? 1 : 0;
            acc_cyc[k] = c;
            k++;
         end
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("rr accept_count", k, 4);
      chk("rr ready_cycles", rdy_cycles, 4);
      chk("rr order0", order[0], 0);
      chk("rr order1", order[1], 1);
      chk("rr order2", order[2], 0);
      chk("rr order3", order[3], 1);
      chk("rr first_cycle", acc_cyc[0], 0);
      for (int i = 1; i < 4; i++) chk("rr interval", acc_cyc[i] - acc_cyc[i-1], N + 2);
      repeat (N + 3) @(negedge clk);

      for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // Backpressure: rsp_ready low for three RESP cycles
      @(negedge clk);
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0FFF; req0_sub = 1'b0;
      #1;
      chk("bp accept_ready", req0_ready, 1);
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h000E; req1_sub = 1'b1;
      wait_rsp(lat);
      chk("bp latency", lat, N);
      chk("bp data", rsp_data, 16'h2233);
      held = rsp_data;
      for (int j = 0; j < 3; j++) begin
         chk("bp hold_valid", rsp_valid, 1);
         chk("bp hold_data", rsp_data, held);
         chk("bp hold_id", rsp_id, 0);
         chk("bp hold_cout", rsp_cout, 0);
         chk("bp hold_ovf", rsp_ovf, 0);
         chk("bp hold_ready0", req0_ready, 0);
         chk("bp hold_ready1", req1_ready, 0);
         @(posedge clk); #1;
      end
      chk("bp cycle4_valid", rsp_valid, 1);
      rsp_ready = 1'b1;
      #1;
      chk("bp handshake_ready0", req0_ready, 0);
      chk("bp handshake_ready1", req1_ready, 0);
      @(posedge clk); #1;
      chk("bp completed", rsp_valid, 0);
      chk("bp next_ready1", req1_ready, 1);
      chk("bp next_ready0", req0_ready, 0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("bp exec_ready1", req1_ready, 0);
      wait_rsp(lat);
      chk("bp2 latency", lat, N);
      chk("bp2 data", rsp_data, 16'hFFF7);
      chk("bp2 id", rsp_id, 1);
      @(posedge clk); #1;

      // Reset in the second EXEC cycle after a req0 grant (pointer now on req1)
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 16'h1111; req0_b = 16'h2222; req0_sub = 1'b0;
      #1;
      chk("rst2 accept_ready", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_a = 16'h0003; req0_b = 16'h0004;
      req1_valid = 1'b1; req1_a = 16'h0009; req1_b = 16'h0001;
      #1;
      chk("rst2 rsp_valid", rsp_valid, 0);
      chk("rst2 rsp_data", rsp_data, 0);
      chk("rst2 rsp_cout", rsp_cout, 0);
      chk("rst2 rsp_ovf", rsp_ovf, 0);
      chk("rst2 rsp_id", rsp_id, 0);
      chk("rst2 req0_ready", req0_ready, 0);
      chk("rst2 req1_ready", req1_ready, 0);
      repeat (3) @(negedge clk);
      chk("rst2 no_rsp", rsp_valid, 0);
      rst_n = 1'b1;
      #1;
      chk("rst2 grant0", req0_ready, 1);
      chk("rst2 grant1", req1_ready, 0);
      chk("rst2 no_rsp_after", rsp_valid, 0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_rsp(lat);
      chk("rst2 latency", lat, N);
      chk("rst2 data", rsp_data, 16'h0007);
      chk("rst2 id", rsp_id, 0);
      @(posedge clk); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
